// File: rtl/piezo_pkg.sv
// Shared thresholds and filter state type for the piezo alarm path.
// The piezo driver imports the same BATT_LOW_THRES so both blocks agree on the low-battery level.
package piezo_pkg;

   localparam int          MOVE_THRES     = 128;
   localparam int          OVR_SPD_THRES  = 1536;
   localparam logic [11:0] BATT_LOW_THRES = 12'h800;
   localparam logic [11:0] BATT_HYST      = 12'h040;
   localparam int          FILT_SMP       = 8;

   typedef enum logic {FLT_OFF, FLT_ON} flt_state_t;

endpackage

// File: rtl/alarm_filt.sv
// Debounce filter for one alarm flag: the flag toggles after FILT_SMP
// consecutive qualifying samples. A non-qualifying sample restarts the run.
module alarm_filt
   import piezo_pkg::*;
#(
   parameter int FILT_SMP = piezo_pkg::FILT_SMP
) (
   input  logic clk,
   input  logic rst_n,
   input  logic vld,
   input  logic qual,
   input  logic clr,
   output logic flag
);

   localparam int               CNT_W    = $clog2(FILT_SMP + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_SMP - 1);

   flt_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FLT_OFF;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // NOTE: every signal gets a hold default first, so no path through this block infers a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (clr) begin
         state_nxt = FLT_OFF;
         cnt_nxt   = '0;
      end else if (vld) begin
         if (!qual) begin
            cnt_nxt = '0;
         end else if (cnt == CNT_LAST) begin
            state_nxt = (state == FLT_ON) ? FLT_OFF : FLT_ON;
            cnt_nxt   = '0;
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end
   end

   always_comb flag = (state == FLT_ON);

endmodule

// File: rtl/piezo_alarm_gen.sv
// Turns sampled wheel-speed and battery readings into debounced moving,
// overspeed and low-battery levels, plus a pulse when any of them changes.
module piezo_alarm_gen
   import piezo_pkg::*;
#(
   parameter int                SPD_W          = 11,
   parameter int                BATT_W         = 12,
   parameter int                MOVE_THRES     = piezo_pkg::MOVE_THRES,
   parameter int                OVR_SPD_THRES  = piezo_pkg::OVR_SPD_THRES,
   parameter logic [BATT_W-1:0] BATT_LOW_THRES = piezo_pkg::BATT_LOW_THRES,
   parameter logic [BATT_W-1:0] BATT_HYST      = piezo_pkg::BATT_HYST,
   parameter int                FILT_SMP       = piezo_pkg::FILT_SMP
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    vld,
   input  logic signed [SPD_W-1:0] lft_spd,
   input  logic signed [SPD_W-1:0] rght_spd,
   input  logic [BATT_W-1:0]       batt,
   input  logic                    en_steer,
   output logic                    moving,
   output logic                    ovr_spd,
   output logic                    batt_low,
   output logic                    alarm_chg
);

   localparam logic [SPD_W:0]   MOVE_T   = (SPD_W+1)'(MOVE_THRES);
   localparam logic [SPD_W-1:0] OVR_T    = SPD_W'(OVR_SPD_THRES);
   localparam logic [BATT_W:0]  BATT_CLR = {1'b0, BATT_LOW_THRES} + {1'b0, BATT_HYST};

   logic signed [SPD_W:0] spd_sum, spd_avg;
   logic [SPD_W:0]        abs_avg;
   logic [SPD_W-1:0]      abs_lft, abs_rght;
   logic                  mov_raw, ovr_raw;
   logic                  mov_qual, ovr_qual, batt_qual;
   logic [2:0]            flags, flags_d;

   // The average keeps one extra bit so |avg| of the most negative sum stays exact.
   always_comb begin
      spd_sum  = {lft_spd[SPD_W-1], lft_spd} + {rght_spd[SPD_W-1], rght_spd};
      spd_avg  = spd_sum >>> 1;
      abs_avg  = spd_avg[SPD_W] ? (~spd_avg + 1'b1) : spd_avg;
      abs_lft  = lft_spd[SPD_W-1] ? (~lft_spd + 1'b1) : lft_spd;
      abs_rght = rght_spd[SPD_W-1] ? (~rght_spd + 1'b1) : rght_spd;
      mov_raw  = en_steer && (abs_avg > MOVE_T);
      ovr_raw  = (abs_lft > OVR_T) || (abs_rght > OVR_T);
   end

   // A sample qualifies when it argues for the opposite of the current flag.
   always_comb begin
      mov_qual  = mov_raw ^ moving;
      ovr_qual  = ovr_raw ^ ovr_spd;
      batt_qual = batt_low ? ({1'b0, batt} >= BATT_CLR) : (batt < BATT_LOW_THRES);
   end

   alarm_filt #(.FILT_SMP(FILT_SMP)) u_mov_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .vld   (vld),
      .qual  (mov_qual),
      .clr   (!en_steer),
      .flag  (moving)
   );

   alarm_filt #(.FILT_SMP(FILT_SMP)) u_ovr_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .vld   (vld),
      .qual  (ovr_qual),
      .clr   (1'b0),
      .flag  (ovr_spd)
   );

   alarm_filt #(.FILT_SMP(FILT_SMP)) u_batt_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .vld   (vld),
      .qual  (batt_qual),
      .clr   (1'b0),
      .flag  (batt_low)
   );

   assign flags = {moving, ovr_spd, batt_low};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_d   <= '0;
         alarm_chg <= 1'b0;
      end else begin
         flags_d   <= flags;
         alarm_chg <= (flags != flags_d);
      end
   end

endmodule

// File: tb/tb_piezo_alarm_gen.sv
// Self-checking bench for piezo_alarm_gen: directed scenarios plus a randomized run
// compared against an integer-arithmetic reference model.
module tb_piezo_alarm_gen;

   // 12-bit speeds so overspeed readings such as -1600 or 1537 are representable.
   localparam int SPD_W   = 12;
   localparam int BATT_W  = 12;
   localparam int FILT    = 4;
   localparam int MOVE_T  = 128;
   localparam int OVR_T   = 1536;
   localparam int BLOW_T  = 'h800;
   localparam int BCLR_T  = 'h840;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    vld = 1'b0;
   logic signed [SPD_W-1:0] lft_spd = '0;
   logic signed [SPD_W-1:0] rght_spd = '0;
   logic [BATT_W-1:0]       batt = '0;
   logic                    en_steer = 1'b0;
   logic                    moving, ovr_spd, batt_low, alarm_chg;

   int checks = 0;
   int failures = 0;

   int cur_l, cur_r, cur_b;
   bit cur_en;

   // Reference model: per-flag level and length of the current qualifying run.
   bit       m_flag [3];
   int       m_run  [3];
   bit [2:0] m_prev, m_prev2;

   always #5 clk = ~clk;

   piezo_alarm_gen #(
      .SPD_W    (SPD_W),
      .BATT_W   (BATT_W),
      .FILT_SMP (FILT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .vld       (vld),
      .lft_spd   (lft_spd),
      .rght_spd  (rght_spd),
      .batt      (batt),
      .en_steer  (en_steer),
      .moving    (moving),
      .ovr_spd   (ovr_spd),
      .batt_low  (batt_low),
      .alarm_chg (alarm_chg)
   );

   function automatic int avg_floor(int a, int b);
      int s = a + b;
      return (s >= 0) ? s / 2 : -((1 - s) / 2);
   endfunction

   function automatic int iabs(int x);
      return (x < 0) ? -x : x;
   endfunction

   function automatic bit [3:0] exp_vec();
      return {m_flag[0], m_flag[1], m_flag[2], m_prev != m_prev2};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_flag[i] = 1'b0;
         m_run[i]  = 0;
      end
      m_prev  = '0;
      m_prev2 = '0;
   endtask

   task automatic model_step(input bit v, input int l, input int r, input int b, input bit en);
      bit raw [3];
      bit q   [3];
      raw[0] = en && (iabs(avg_floor(l, r)) > MOVE_T);
      raw[1] = (iabs(l) > OVR_T) || (iabs(r) > OVR_T);
      q[0]   = raw[0] != m_flag[0];
      q[1]   = raw[1] != m_flag[1];
      q[2]   = m_flag[2] ? (b >= BCLR_T) : (b < BLOW_T);
      m_prev2 = m_prev;
      m_prev  = {m_flag[0], m_flag[1], m_flag[2]};
      for (int i = 0; i < 3; i++) begin
         if (i == 0 && !en) begin
            m_flag[0] = 1'b0;
            m_run[0]  = 0;
         end else if (v) begin
            if (q[i]) begin
               m_run[i]++;
               if (m_run[i] == FILT) begin
                  m_flag[i] = !m_flag[i];
                  m_run[i]  = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
      end
   endtask

   // Drive one cycle of inputs, advance the model, and land 1 time unit after the edge.
   task automatic step(input bit v, input int l, input int r, input int b, input bit en);
      vld      = v;
      lft_spd  = SPD_W'(l);
      rght_spd = SPD_W'(r);
      batt     = BATT_W'(b);
      en_steer = en;
      cur_l = l; cur_r = r; cur_b = b; cur_en = en;
      model_step(v, l, r, b, en);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, cur_l, cur_r, cur_b, cur_en);
   endtask

   task automatic do_reset(input bit en);
      vld   = 1'b0;
      rst_n = 1'b0;
      cur_l = 0; cur_r = 0; cur_b = 'hA00; cur_en = en;
      @(posedge clk); #1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, cur_l, cur_r, cur_b, cur_en);
   endtask

   task automatic test_reset();
      bit [3:0] outs;
      rst_n = 1'b0;
      repeat (4) begin
         vld      = 1'($urandom);
         lft_spd  = SPD_W'($urandom);
         rght_spd = SPD_W'($urandom);
         batt     = BATT_W'($urandom);
         en_steer = 1'($urandom);
         @(posedge clk); #1;
         outs = {moving, ovr_spd, batt_low, alarm_chg};
         checks++;
         if (outs !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 0000", outs);
         end
      end
      do_reset(1'b1);
      repeat (3) step(1'b1, 300, 300, 'hA00, 1'b1);
      do_reset(1'b1);
      step(1'b1, 300, 300, 'hA00, 1'b1);
      checks++;
      if (moving !== 1'b0) begin
         failures++;
         $display("FAIL reset_discards_count: moving=%b expected 0", moving);
      end
      repeat (3) step(1'b1, 300, 300, 'hA00, 1'b1);
      checks++;
      if (moving !== 1'b1) begin
         failures++;
         $display("FAIL reset_recount: moving=%b expected 1", moving);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (moving !== 1'b0) begin
         failures++;
         $display("FAIL reset_async: moving=%b expected 0", moving);
      end
   endtask

   task automatic test_moving();
      do_reset(1'b1);
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 300, 300, 'hA00, 1'b1);
         checks++;
         if (moving !== (k == 3)) begin
            failures++;
            $display("FAIL mov_sample%0d: moving=%b expected %b", k + 1, moving, k == 3);
         end
         if (k < 3) idle(4);
      end
      idle(1);
      checks++;
      if (alarm_chg !== 1'b1) begin
         failures++;
         $display("FAIL mov_chg_pulse: alarm_chg=%b expected 1", alarm_chg);
      end
      idle(1);
      checks++;
      if (alarm_chg !== 1'b0) begin
         failures++;
         $display("FAIL mov_chg_single: alarm_chg=%b expected 0", alarm_chg);
      end
      step(1'b0, 0, 0, 'hA00, 1'b0);
      repeat (3) step(1'b1, 300, 300, 'hA00, 1'b1);
      step(1'b1, 0, 0, 'hA00, 1'b1);
      repeat (3) step(1'b1, 300, 300, 'hA00, 1'b1);
      checks++;
      if (moving !== 1'b0) begin
         failures++;
         $display("FAIL mov_broken_run: moving=%b expected 0", moving);
      end
      step(1'b1, 300, 300, 'hA00, 1'b1);
      checks++;
      if (moving !== 1'b1) begin
         failures++;
         $display("FAIL mov_after_break: moving=%b expected 1", moving);
      end
   endtask

   task automatic test_ovr();
      do_reset(1'b1);
      for (int k = 0; k < 4; k++) begin
         step(1'b1, -1600, 0, 'hA00, 1'b1);
         checks++;
         if (ovr_spd !== (k == 3)) begin
            failures++;
            $display("FAIL ovr_sample%0d: ovr_spd=%b expected %b", k + 1, ovr_spd, k == 3);
         end
      end
      repeat (4) step(1'b1, 0, 0, 'hA00, 1'b1);
      checks++;
      if (ovr_spd !== 1'b0) begin
         failures++;
         $display("FAIL ovr_clear: ovr_spd=%b expected 0", ovr_spd);
      end
      do_reset(1'b1);
      repeat (4) step(1'b1, -1024, -1024, 'hA00, 1'b1);
      checks++;
      if ({moving, ovr_spd} !== 2'b10) begin
         failures++;
         $display("FAIL ovr_neg1024: moving,ovr_spd=%b expected 10", {moving, ovr_spd});
      end
      do_reset(1'b1);
      repeat (4) step(1'b1, 1536, 1536, 'hA00, 1'b1);
      checks++;
      if (ovr_spd !== 1'b0) begin
         failures++;
         $display("FAIL ovr_at_thres: ovr_spd=%b expected 0", ovr_spd);
      end
      repeat (4) step(1'b1, 1537, -1537, 'hA00, 1'b1);
      checks++;
      if ({moving, ovr_spd} !== 2'b01) begin
         failures++;
         $display("FAIL ovr_above_thres: moving,ovr_spd=%b expected 01", {moving, ovr_spd});
      end
      do_reset(1'b1);
      repeat (4) step(1'b1, -2048, -2048, 'hA00, 1'b1);
      checks++;
      if ({moving, ovr_spd} !== 2'b11) begin
         failures++;
         $display("FAIL ovr_most_neg: moving,ovr_spd=%b expected 11", {moving, ovr_spd});
      end
   endtask

   task automatic test_batt();
      bit held = 1'b1;
      do_reset(1'b1);
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 0, 0, 'h7FF, 1'b1);
         checks++;
         if (batt_low !== (k == 3)) begin
            failures++;
            $display("FAIL batt_set%0d: batt_low=%b expected %b", k + 1, batt_low, k == 3);
         end
      end
      repeat (10) begin
         step(1'b1, 0, 0, 'h83F, 1'b1);
         held &= (batt_low === 1'b1);
      end
      checks++;
      if (held !== 1'b1) begin
         failures++;
         $display("FAIL batt_in_band: batt_low dropped inside band, expected to stay 1");
      end
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 0, 0, 'h840, 1'b1);
         checks++;
         if (batt_low !== (k != 3)) begin
            failures++;
            $display("FAIL batt_clr%0d: batt_low=%b expected %b", k + 1, batt_low, k != 3);
         end
         idle(3);
      end
      repeat (5) step(1'b1, 0, 0, 'h800, 1'b1);
      checks++;
      if (batt_low !== 1'b0) begin
         failures++;
         $display("FAIL batt_at_thres: batt_low=%b expected 0", batt_low);
      end
   endtask

   task automatic test_en_steer();
      do_reset(1'b1);
      repeat (4) step(1'b1, 300, 300, 'hA00, 1'b1);
      idle(2);
      step(1'b0, 300, 300, 'hA00, 1'b0);
      checks++;
      if (moving !== 1'b0) begin
         failures++;
         $display("FAIL en_drop: moving=%b expected 0", moving);
      end
      idle(1);
      checks++;
      if (alarm_chg !== 1'b1) begin
         failures++;
         $display("FAIL en_drop_chg: alarm_chg=%b expected 1", alarm_chg);
      end
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 300, 300, 'hA00, 1'b1);
         checks++;
         if (moving !== (k == 3)) begin
            failures++;
            $display("FAIL en_rise%0d: moving=%b expected %b", k + 1, moving, k == 3);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset(1'b1);
      repeat (3) step(1'b1, 1600, -1600, 'h700, 1'b1);
      step(1'b1, 1600, -1600, 'h700, 1'b1);
      checks++;
      if ({moving, ovr_spd, batt_low, alarm_chg} !== 4'b0110) begin
         failures++;
         $display("FAIL dual_rise: outs=%b expected 0110", {moving, ovr_spd, batt_low, alarm_chg});
      end
      idle(1);
      checks++;
      if (alarm_chg !== 1'b1) begin
         failures++;
         $display("FAIL dual_chg: alarm_chg=%b expected 1", alarm_chg);
      end
      idle(1);
      checks++;
      if (alarm_chg !== 1'b0) begin
         failures++;
         $display("FAIL dual_chg_single: alarm_chg=%b expected 0", alarm_chg);
      end
   endtask

   function automatic int pick_spd();
      case ($urandom_range(0, 6))
         0:       return 0;
         1:       return 300;
         2:       return -300;
         3:       return ($urandom_range(0, 1) != 0) ? 129 : 128;
         4:       return ($urandom_range(0, 1) != 0) ? 1537 : -1600;
         5:       return -2048;
         default: return int'($urandom_range(0, 4095)) - 2048;
      endcase
   endfunction

   function automatic int pick_batt();
      case ($urandom_range(0, 5))
         0:       return 'h7FF;
         1:       return 'h800;
         2:       return 'h83F;
         3:       return 'h840;
         4:       return 'hA00;
         default: return int'($urandom_range(0, 4095));
      endcase
   endfunction

   task automatic test_random();
      bit [3:0] got;
      int l = 0, r = 0, b = 'hA00;
      bit en = 1'b1;
      do_reset(1'b1);
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            l = pick_spd();
            r = ($urandom_range(0, 1) != 0) ? l : pick_spd();
            b = pick_batt();
         end
         if ($urandom_range(0, 39) == 0) en = !en;
         step($urandom_range(0, 2) != 0, l, r, b, en);
         got = {moving, ovr_spd, batt_low, alarm_chg};
         checks++;
         if (got !== exp_vec()) begin
            failures++;
            $display("FAIL random_step%0d: outs=%b expected %b", n, got, exp_vec());
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_moving();
      test_ovr();
      test_batt();
      test_en_steer();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
